// File: rtl/ysyx_25030093_mem_slave_if.sv
// AXI4-Lite-style read/write channel bundle between the core's LSU/IFU and the memory slave.
interface ysyx_25030093_mem_slave_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25030093_mem_slave.sv
// Memory responder: one outstanding read and one outstanding write, fixed programmable
// latency, byte-lane writes into an internal word array. All outputs come from flops.
module ysyx_25030093_mem_slave #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned AW_LOG2 = 10,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned WR_LAT  = 1
) (
  input logic clk,
  input logic rst_n,
  ysyx_25030093_mem_slave_if.slave bus
);
  localparam int unsigned DEPTH       = 1 << AW_LOG2;
  localparam logic [15:0] RD_CNT_INIT = 16'(RD_LAT - 1);
  localparam logic [15:0] WR_CNT_INIT = 16'(WR_LAT - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;

  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr >= BASE) && (33'(addr - BASE) < (33'd1 << (AW_LOG2 + 2)));
  endfunction

  // Byte offsets below 2 are dropped: sub-word alignment is the LSU's business.
  function automatic logic [AW_LOG2-1:0] word_index(input logic [31:0] addr);
    return AW_LOG2'((addr - BASE) >> 2);
  endfunction

  logic [31:0] mem_r [0:DEPTH-1];

  r_state_t    r_state_r, r_state_next;
  logic [15:0] rd_cnt_r, rd_cnt_next;
  logic [31:0] rd_addr_r, rd_addr_next;
  logic        arready_r, arready_next;
  logic        rvalid_r, rvalid_next;
  logic [31:0] rdata_r, rdata_next;
  logic [1:0]  rresp_r, rresp_next;

  w_state_t    w_state_r, w_state_next;
  logic [15:0] wr_cnt_r, wr_cnt_next;
  logic [31:0] wr_addr_r, wr_addr_next;
  logic [31:0] wr_data_r, wr_data_next;
  logic [3:0]  wr_strb_r, wr_strb_next;
  logic        awready_r, awready_next;
  logic        wready_r, wready_next;
  logic        bvalid_r, bvalid_next;
  logic [1:0]  bresp_r, bresp_next;

  logic aw_hs_s, w_hs_s, commit_s, wr_in_range_s;

  assign aw_hs_s       = bus.awvalid && awready_r;
  assign w_hs_s        = bus.wvalid && wready_r;
  assign wr_in_range_s = addr_in_range(wr_addr_r);

  // Read channel next-state and output values.
  always_comb begin
    r_state_next = r_state_r;
    rd_cnt_next  = rd_cnt_r;
    rd_addr_next = rd_addr_r;
    arready_next = arready_r;
    rvalid_next  = rvalid_r;
    rdata_next   = rdata_r;
    rresp_next   = rresp_r;
    case (r_state_r)
      R_IDLE: begin
        if (bus.arvalid && arready_r) begin
          rd_addr_next = bus.araddr;
          arready_next = 1'b0;
          rd_cnt_next  = RD_CNT_INIT;
          r_state_next = R_WAIT;
        end else begin
          arready_next = 1'b1;
        end
      end
      R_WAIT: begin
        if (rd_cnt_r == 16'd0) begin
          if (addr_in_range(rd_addr_r)) begin
            rdata_next = mem_r[word_index(rd_addr_r)];
            rresp_next = RESP_OKAY;
          end else begin
            rdata_next = 32'd0;
            rresp_next = RESP_SLVERR;
          end
          rvalid_next  = 1'b1;
          r_state_next = R_RESP;
        end else begin
          rd_cnt_next = rd_cnt_r - 16'd1;
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          rvalid_next  = 1'b0;
          arready_next = 1'b1;
          r_state_next = R_IDLE;
        end else begin
          rvalid_next = 1'b1;
        end
      end
      default: begin
        r_state_next = R_IDLE;
        arready_next = 1'b1;
        rvalid_next  = 1'b0;
      end
    endcase
  end

  // Read channel state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_r <= R_IDLE;
      rd_cnt_r  <= 16'd0;
      rd_addr_r <= 32'd0;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
    end else begin
      r_state_r <= r_state_next;
      rd_cnt_r  <= rd_cnt_next;
      rd_addr_r <= rd_addr_next;
      arready_r <= arready_next;
      rvalid_r  <= rvalid_next;
      rdata_r   <= rdata_next;
      rresp_r   <= rresp_next;
    end
  end

  // Write channel next-state; AW and W are captured independently while idle.
  always_comb begin
    w_state_next = w_state_r;
    wr_cnt_next  = wr_cnt_r;
    wr_addr_next = wr_addr_r;
    wr_data_next = wr_data_r;
    wr_strb_next = wr_strb_r;
    awready_next = awready_r;
    wready_next  = wready_r;
    bvalid_next  = bvalid_r;
    bresp_next   = bresp_r;
    commit_s     = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          wr_addr_next = bus.awaddr;
          awready_next = 1'b0;
        end else begin
          awready_next = awready_r;
        end
        if (w_hs_s) begin
          wr_data_next = bus.wdata;
          wr_strb_next = bus.wstrb;
          wready_next  = 1'b0;
        end else begin
          wready_next = wready_r;
        end
        if ((aw_hs_s || !awready_r) && (w_hs_s || !wready_r)) begin
          wr_cnt_next  = WR_CNT_INIT;
          w_state_next = W_WAIT;
        end else begin
          w_state_next = W_IDLE;
        end
      end
      W_WAIT: begin
        if (wr_cnt_r == 16'd0) begin
          commit_s     = 1'b1;
          bresp_next   = wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
          bvalid_next  = 1'b1;
          w_state_next = W_RESP;
        end else begin
          wr_cnt_next = wr_cnt_r - 16'd1;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_next  = 1'b0;
          awready_next = 1'b1;
          wready_next  = 1'b1;
          w_state_next = W_IDLE;
        end else begin
          bvalid_next = 1'b1;
        end
      end
      default: begin
        w_state_next = W_IDLE;
        awready_next = 1'b1;
        wready_next  = 1'b1;
        bvalid_next  = 1'b0;
      end
    endcase
  end

  // Write channel state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_r <= W_IDLE;
      wr_cnt_r  <= 16'd0;
      wr_addr_r <= 32'd0;
      wr_data_r <= 32'd0;
      wr_strb_r <= 4'd0;
      awready_r <= 1'b1;
      wready_r  <= 1'b1;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      w_state_r <= w_state_next;
      wr_cnt_r  <= wr_cnt_next;
      wr_addr_r <= wr_addr_next;
      wr_data_r <= wr_data_next;
      wr_strb_r <= wr_strb_next;
      awready_r <= awready_next;
      wready_r  <= wready_next;
      bvalid_r  <= bvalid_next;
      bresp_r   <= bresp_next;
    end
  end

  // Array update; a read sampling the same edge sees the pre-write word.
  always_ff @(posedge clk) begin
    if (commit_s && wr_in_range_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_r[i]) begin
          mem_r[word_index(wr_addr_r)][8*i +: 8] <= wr_data_r[8*i +: 8];
        end
      end
    end
  end

  assign bus.arready = arready_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bresp   = bresp_r;
endmodule

// File: tb/tb_ysyx_25030093_mem_slave.sv
// Bench: per-cycle transaction-level model of dut0 (latency 1/1) plus literal checks,
// and a second instance (read latency 5, write latency 3) for latency counting.
module tb_ysyx_25030093_mem_slave;
  localparam int RD_LAT0 = 1;
  localparam int WR_LAT0 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ysyx_25030093_mem_slave_if bus0 ();
  ysyx_25030093_mem_slave_if bus1 ();

  ysyx_25030093_mem_slave #(.BASE(32'h8000_0000), .AW_LOG2(10), .RD_LAT(RD_LAT0), .WR_LAT(WR_LAT0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ysyx_25030093_mem_slave #(.BASE(32'h8000_0000), .AW_LOG2(10), .RD_LAT(5), .WR_LAT(3))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model of dut0 ----------------
  logic [31:0] m_mem [0:1023];
  logic        e_arready, e_rvalid, e_awready, e_wready, e_bvalid;
  logic [31:0] e_rdata;
  logic [1:0]  e_rresp, e_bresp;
  int          rd_wait, wr_wait;
  logic [31:0] rd_a, wr_a, wr_d;
  logic [3:0]  wr_s;

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= 32'h8000_0000) && ((a - 32'h8000_0000) < 32'd4096);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h8000_0000) >> 2);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_arready = 1'b1; e_rvalid = 1'b0; e_rdata = 32'd0; e_rresp = 2'd0;
        e_awready = 1'b1; e_wready = 1'b1; e_bvalid = 1'b0; e_bresp = 2'd0;
        rd_wait = 0; wr_wait = 0;
      end
      check("arready", {31'd0, bus0.arready}, {31'd0, e_arready});
      check("rvalid", {31'd0, bus0.rvalid}, {31'd0, e_rvalid});
      check("awready", {31'd0, bus0.awready}, {31'd0, e_awready});
      check("wready", {31'd0, bus0.wready}, {31'd0, e_wready});
      check("bvalid", {31'd0, bus0.bvalid}, {31'd0, e_bvalid});
      if (e_rvalid) begin
        check("rdata", bus0.rdata, e_rdata);
        check("rresp", {30'd0, bus0.rresp}, {30'd0, e_rresp});
      end
      if (e_bvalid) check("bresp", {30'd0, bus0.bresp}, {30'd0, e_bresp});
      if (rst_n) begin
        // read channel first so a same-edge commit is not visible to the sample
        if (e_rvalid) begin
          if (bus0.rready) begin e_rvalid = 1'b0; e_arready = 1'b1; end
        end else if (rd_wait > 0) begin
          rd_wait--;
          if (rd_wait == 0) begin
            e_rvalid = 1'b1;
            e_rdata  = in_rng(rd_a) ? m_mem[widx(rd_a)] : 32'd0;
            e_rresp  = in_rng(rd_a) ? 2'b00 : 2'b10;
          end
        end else if (bus0.arvalid && e_arready) begin
          rd_a = bus0.araddr; e_arready = 1'b0; rd_wait = RD_LAT0;
        end
        if (e_bvalid) begin
          if (bus0.bready) begin e_bvalid = 1'b0; e_awready = 1'b1; e_wready = 1'b1; end
        end else if (wr_wait > 0) begin
          wr_wait--;
          if (wr_wait == 0) begin
            e_bvalid = 1'b1;
            e_bresp  = in_rng(wr_a) ? 2'b00 : 2'b10;
            if (in_rng(wr_a))
              for (int i = 0; i < 4; i++)
                if (wr_s[i]) m_mem[widx(wr_a)][8*i +: 8] = wr_d[8*i +: 8];
          end
        end else begin
          if (bus0.awvalid && e_awready) begin wr_a = bus0.awaddr; e_awready = 1'b0; end
          if (bus0.wvalid && e_wready) begin wr_d = bus0.wdata; wr_s = bus0.wstrb; e_wready = 1'b0; end
          if (!e_awready && !e_wready) wr_wait = WR_LAT0;
        end
      end
    end
  end

  // ---------------- dut0 drivers ----------------
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output int lat);
    int n = 0;
    bus0.araddr = a; bus0.arvalid = 1'b1;
    @(negedge clk);
    while (!bus0.arready && n < 50) begin @(negedge clk); n++; end
    check("ar_handshake_bound", {31'd0, n < 50}, 32'd1);
    @(posedge clk); #1 bus0.arvalid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus0.rvalid && lat < 50);
    check("rvalid_bound", {31'd0, lat < 50}, 32'd1);
    d = bus0.rdata; r = bus0.rresp;
    bus0.rready = 1'b1;
    @(posedge clk); #1 bus0.rready = 1'b0;
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic use_aw, input logic use_w);
    int n = 0;
    if (use_aw) begin bus0.awaddr = a; bus0.awvalid = 1'b1; end
    if (use_w) begin bus0.wdata = d; bus0.wstrb = s; bus0.wvalid = 1'b1; end
    @(negedge clk);
    while (((use_aw && !bus0.awready) || (use_w && !bus0.wready)) && n < 50) begin
      @(negedge clk); n++;
    end
    check("aw_w_handshake_bound", {31'd0, n < 50}, 32'd1);
    @(posedge clk); #1 bus0.awvalid = 1'b0; bus0.wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r, output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus0.bvalid && lat < 50);
    check("bvalid_bound", {31'd0, lat < 50}, 32'd1);
    r = bus0.bresp;
    bus0.bready = 1'b1;
    @(posedge clk); #1 bus0.bready = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output int lat);
    send_aw_w(a, d, s, 1'b1, 1'b1);
    wait_b(r, lat);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    {bus0.araddr, bus0.arvalid, bus0.rready, bus0.awaddr, bus0.awvalid} = '0;
    {bus0.wdata, bus0.wstrb, bus0.wvalid, bus0.bready} = '0;
    {bus1.araddr, bus1.arvalid, bus1.rready, bus1.awaddr, bus1.awvalid} = '0;
    {bus1.wdata, bus1.wstrb, bus1.wvalid, bus1.bready} = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_arready", {31'd0, bus0.arready}, 32'd1);
    check("rst_awready", {31'd0, bus0.awready}, 32'd1);
    check("rst_wready", {31'd0, bus0.wready}, 32'd1);
    check("rst_rvalid", {31'd0, bus0.rvalid}, 32'd0);
    check("rst_bvalid", {31'd0, bus0.bvalid}, 32'd0);
    check("rst_rdata", bus0.rdata, 32'd0);
    check("rst_resp", {28'd0, bus0.rresp, bus0.bresp}, 32'd0);

    // full-word store then load
    write_word(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
    check("sw_bresp", {30'd0, r}, 32'd0);
    check("sw_blat", lat, 32'd1);
    do_read(32'h8000_0010, d, r, lat);
    check("lw_data", d, 32'hDEAD_BEEF);
    check("lw_rresp", {30'd0, r}, 32'd0);
    check("lw_rlat", lat, 32'd1);

    // byte lane 1 store, then empty strobe
    write_word(32'h8000_0010, 32'h0000_5500, 4'b0010, r, lat);
    do_read(32'h8000_0010, d, r, lat);
    check("sb_data", d, 32'hDEAD_55EF);
    write_word(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, r, lat);
    check("strb0_bresp", {30'd0, r}, 32'd0);
    do_read(32'h8000_0010, d, r, lat);
    check("strb0_data", d, 32'hDEAD_55EF);

    // W first, three idle cycles, then AW
    send_aw_w(32'd0, 32'hA5A5_0F0F, 4'hF, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 send_aw_w(32'h8000_0014, 32'd0, 4'd0, 1'b1, 1'b0);
    wait_b(r, lat);
    check("wfirst_blat", lat, 32'd1);
    do_read(32'h8000_0014, d, r, lat);
    check("wfirst_data", d, 32'hA5A5_0F0F);

    // out of range below BASE and just past the array
    write_word(32'h8000_0000, 32'hCAFE_F00D, 4'hF, r, lat);
    write_word(32'h8000_0FFC, 32'h1234_5678, 4'hF, r, lat);
    write_word(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, r, lat);
    check("oor_low_bresp", {30'd0, r}, 32'd2);
    write_word(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, r, lat);
    check("oor_high_bresp", {30'd0, r}, 32'd2);
    do_read(32'h7FFF_FFFC, d, r, lat);
    check("oor_low_rresp", {30'd0, r}, 32'd2);
    check("oor_low_rdata", d, 32'd0);
    do_read(32'h8000_1000, d, r, lat);
    check("oor_high_rresp", {30'd0, r}, 32'd2);
    do_read(32'h8000_0000, d, r, lat);
    check("word0_intact", d, 32'hCAFE_F00D);
    do_read(32'h8000_0FFC, d, r, lat);
    check("lastword_intact", d, 32'h1234_5678);

    // read backpressure with a same-edge write to the sampled word
    write_word(32'h8000_0020, 32'h1111_1111, 4'hF, r, lat);
    bus0.araddr = 32'h8000_0020; bus0.arvalid = 1'b1;
    bus0.awaddr = 32'h8000_0020; bus0.wdata = 32'h2222_2222; bus0.wstrb = 4'hF;
    bus0.awvalid = 1'b1; bus0.wvalid = 1'b1;
    @(posedge clk);
    #1 bus0.araddr = 32'h8000_0040; bus0.awvalid = 1'b0; bus0.wvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("bp_rvalid", {31'd0, bus0.rvalid}, 32'd1);
    check("bp_rdata_old", bus0.rdata, 32'h1111_1111);
    check("bp_arready", {31'd0, bus0.arready}, 32'd0);
    bus0.rready = 1'b1; bus0.arvalid = 1'b0; bus0.bready = 1'b1;
    @(posedge clk);
    #1 bus0.rready = 1'b0; bus0.bready = 1'b0;
    do_read(32'h8000_0020, d, r, lat);
    check("bp_new_data", d, 32'h2222_2222);

    // asynchronous reset while a read response is pending
    bus0.araddr = 32'h8000_0010; bus0.arvalid = 1'b1;
    @(posedge clk); #1 bus0.arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_rvalid", {31'd0, bus0.rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rvalid", {31'd0, bus0.rvalid}, 32'd0);
    check("async_rst_arready", {31'd0, bus0.arready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    do_read(32'h8000_0010, d, r, lat);
    check("persist_after_rst", d, 32'hDEAD_55EF);

    // second instance: longer latencies counted from the handshake edge
    bus1.awaddr = 32'h8000_0010; bus1.wdata = 32'hDEAD_BEEF; bus1.wstrb = 4'hF;
    bus1.awvalid = 1'b1; bus1.wvalid = 1'b1;
    @(posedge clk); #1 bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus1.bvalid && lat < 50);
    check("lat3_blat", lat, 32'd3);
    check("lat3_bresp", {30'd0, bus1.bresp}, 32'd0);
    bus1.bready = 1'b1; @(posedge clk); #1 bus1.bready = 1'b0;
    bus1.araddr = 32'h8000_0010; bus1.arvalid = 1'b1;
    @(posedge clk); #1 bus1.arvalid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus1.rvalid && lat < 50);
    check("lat5_rlat", lat, 32'd5);
    check("lat5_rdata", bus1.rdata, 32'hDEAD_BEEF);
    check("lat5_rresp", {30'd0, bus1.rresp}, 32'd0);
    bus1.rready = 1'b1; @(posedge clk); #1 bus1.rready = 1'b0;

    repeat (3) @(posedge clk);
    #1 $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
